// File: rtl/seven_segment_pkg.sv
// Segment patterns for the seven-segment display interface, shared with the encoder side.
// Bit order is {a,b,c,d,e,f,g} with bit 6 = a, active-high.
package seven_segment_pkg;

    typedef logic [6:0] seg_pat_t;

    // Indexed by hex value 0..F
    localparam seg_pat_t SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    localparam seg_pat_t BLANK = 7'b0000000;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of a segment pattern into its hex value.
// hit is low when the pattern is not one of the sixteen table entries.
module seg_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] val,
    output logic       hit
);

    always_comb begin
        val = '0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                val = 4'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Receiver for a multiplexed seven-segment bus: debounces each digit slot and recovers its hex value.
// Optional macro SEVEN_SEGMENT_READER_BLANK_EN accepts an all-dark digit as a legal (invalid-value) capture.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    pattern_err,
    output logic                    anode_err
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

    logic [NUM_DIGITS-1:0] an_q;
    seg_pat_t              seg_q;
    logic [7:0]            cnt;

    logic [2:0]            an_idx;
    logic                  an_multi;
    logic                  an_idle;
    logic                  an_hold;
    logic                  capture;
    logic [3:0]            dec_val;
    logic                  dec_hit;
    logic                  is_blank;

    // At the capture edge seg equals seg_q, so decoding the registered copy is equivalent
    seg_pattern_decode u_decode (
        .seg (seg_q),
        .val (dec_val),
        .hit (dec_hit)
    );

    always_comb begin
        an_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an[i]) an_idx = 3'(i);
        end
        an_idle  = (an == '0);
        an_multi = |(an & (an - NUM_DIGITS'(1)));
        an_hold  = (an == an_q) && (seg == seg_q) && (cnt != 8'd0);
        capture  = !an_idle && !an_multi && an_hold && (cnt == STABLE_MAX - 8'd1);
`ifdef SEVEN_SEGMENT_READER_BLANK_EN
        is_blank = (seg_q == BLANK);
`else
        is_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q        <= '0;
            seg_q       <= '0;
            cnt         <= '0;
            digits      <= '0;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            upd         <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;

            if (an_idle) begin
                cnt <= '0;
            end else if (an_multi) begin
                cnt       <= '0;
                anode_err <= 1'b1;
            end else if (an_hold) begin
                // Saturating at STABLE_MAX is what prevents re-capturing a held pattern
                if (cnt != STABLE_MAX) cnt <= cnt + 8'd1;
            end else begin
                cnt <= 8'd1;
            end

            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an[i]) begin
                        if (is_blank) begin
                            digits[4*i +: 4] <= 4'd0;
                            digit_valid[i]   <= 1'b0;
                        end else if (dec_hit) begin
                            digits[4*i +: 4] <= dec_val;
                            digit_valid[i]   <= 1'b1;
                        end else begin
                            digit_valid[i]   <= 1'b0;
                        end
                    end
                end
                if (!is_blank) begin
                    upd         <= dec_hit;
                    pattern_err <= !dec_hit;
                    if (dec_hit) upd_idx <= an_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Table-driven bench for seven_segment_reader with a capture scoreboard.
// Build with +define+SEVEN_SEGMENT_READER_BLANK_EN to exercise the blank-digit variant.
module tb_seven_segment_reader;

    localparam int ND = 4;

    logic          clk;
    logic          rst;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic          upd;
    logic [2:0]    upd_idx;
    logic          pattern_err;
    logic          anode_err;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_valid (digit_valid),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .pattern_err (pattern_err),
        .anode_err   (anode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    seg;
        logic [ND-1:0] an;
        int            edges;
        int            n_upd;
        logic [2:0]    idx;
        logic [3:0]    val;
        int            n_perr;
        int            n_aerr;
        logic [15:0]   exp_digits;
        logic [ND-1:0] exp_valid;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] val;
    } cap_t;

    vec_t vecs[$];
    cap_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt, perr_cnt, aerr_cnt;

`ifdef SEVEN_SEGMENT_READER_BLANK_EN
    localparam logic [3:0] D3 = 4'h0;
    localparam int BLANK_PERR = 0;
`else
    localparam logic [3:0] D3 = 4'hA;
    localparam int BLANK_PERR = 1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every upd pulse must match the oldest pending expected capture
    always @(negedge clk) begin
        if (upd === 1'b1) begin
            upd_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_upd: upd_idx=%0d with no capture pending", upd_idx);
            end else begin
                cap_t c;
                c = sb.pop_front();
                if (upd_idx !== c.idx || digits[4*c.idx +: 4] !== c.val) begin
                    n_err++;
                    $display("FAIL sb_capture: got idx %0d val %0h expected idx %0d val %0h",
                             upd_idx, digits[4*c.idx +: 4], c.idx, c.val);
                end
            end
        end
        if (pattern_err === 1'b1) perr_cnt++;
        if (anode_err === 1'b1) aerr_cnt++;
    end

    function automatic void add(input logic [6:0] s, input logic [ND-1:0] a, input int e,
                                input int nu, input logic [2:0] ix, input logic [3:0] v,
                                input int np, input int na, input logic [15:0] d,
                                input logic [ND-1:0] dv);
        vec_t r;
        r.seg = s; r.an = a; r.edges = e; r.n_upd = nu; r.idx = ix; r.val = v;
        r.n_perr = np; r.n_aerr = na; r.exp_digits = d; r.exp_valid = dv;
        vecs.push_back(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        seg = 7'b0;
        an  = '0;

        //  seg         an      edges upd idx val perr aerr digits          valid
        add(7'b1101101, 4'b0010, 4,  1, 1, 4'h2, 0, 0, 16'h0020,            4'b0010);
        add(7'b1101101, 4'b0010, 6,  0, 0, 4'h0, 0, 0, 16'h0020,            4'b0010);
        add(7'b0000000, 4'b0000, 1,  0, 0, 4'h0, 0, 0, 16'h0020,            4'b0010);
        add(7'b1101101, 4'b0100, 3,  0, 0, 4'h0, 0, 0, 16'h0020,            4'b0010);
        add(7'b0000000, 4'b0000, 1,  0, 0, 4'h0, 0, 0, 16'h0020,            4'b0010);
        add(7'b0110000, 4'b0001, 5,  1, 0, 4'h1, 0, 0, 16'h0021,            4'b0011);
        add(7'b1111001, 4'b0010, 5,  1, 1, 4'h3, 0, 0, 16'h0031,            4'b0011);
        add(7'b1000111, 4'b0100, 5,  1, 2, 4'hF, 0, 0, 16'h0F31,            4'b0111);
        add(7'b1110111, 4'b1000, 5,  1, 3, 4'hA, 0, 0, 16'hAF31,            4'b1111);
        add(7'b1010101, 4'b0001, 4,  0, 0, 4'h0, 1, 0, 16'hAF31,            4'b1110);
        add(7'b1111111, 4'b0011, 3,  0, 0, 4'h0, 0, 3, 16'hAF31,            4'b1110);
        add(7'b0000000, 4'b1000, 4,  0, 0, 4'h0, BLANK_PERR, 0, {D3, 12'hF31}, 4'b0110);
        add(7'b1111111, 4'b0001, 2,  0, 0, 4'h0, 0, 0, {D3, 12'hF31},       4'b0110);
        add(7'b0110011, 4'b0001, 3,  0, 0, 4'h0, 0, 0, {D3, 12'hF31},       4'b0110);
        add(7'b0110011, 4'b0001, 1,  1, 0, 4'h4, 0, 0, {D3, 12'hF34},       4'b0111);
        add(7'b0011111, 4'b0010, 4,  1, 1, 4'hB, 0, 0, {D3, 12'hFB4},       4'b0111);

        upd_cnt = 0; perr_cnt = 0; aerr_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_pulses", {29'b0, upd, pattern_err, anode_err}, 32'h0);
        check("reset_upd_idx", 32'(upd_idx), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            upd_cnt = 0; perr_cnt = 0; aerr_cnt = 0;
            seg = vecs[i].seg;
            an  = vecs[i].an;
            if (vecs[i].n_upd != 0) sb.push_back('{idx: vecs[i].idx, val: vecs[i].val});
            repeat (vecs[i].edges) @(posedge clk);
            @(negedge clk); #1;
            check($sformatf("v%0d_upd_count", i), 32'(upd_cnt), 32'(vecs[i].n_upd));
            check($sformatf("v%0d_perr_count", i), 32'(perr_cnt), 32'(vecs[i].n_perr));
            check($sformatf("v%0d_aerr_count", i), 32'(aerr_cnt), 32'(vecs[i].n_aerr));
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
            check($sformatf("v%0d_valid", i), 32'(digit_valid), 32'(vecs[i].exp_valid));
        end
        check("sb_drained", 32'(sb.size()), 32'h0);

        // Reset arriving on what would be the capture edge must win
        upd_cnt = 0; perr_cnt = 0; aerr_cnt = 0;
        seg = 7'b0110000;
        an  = 4'b0100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("rst_cap_upd_count", 32'(upd_cnt), 32'h0);
        check("rst_cap_digits", 32'(digits), 32'h0);
        check("rst_cap_valid", 32'(digit_valid), 32'h0);
        check("rst_cap_pulses", {29'b0, upd, pattern_err, anode_err}, 32'h0);

        // After release the same digit captures after a full fresh window
        rst = 1'b0;
        upd_cnt = 0;
        sb.push_back('{idx: 3'd2, val: 4'h1});
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("post_rst_upd_count", 32'(upd_cnt), 32'h1);
        check("post_rst_digits", 32'(digits), 32'h0100);
        check("post_rst_valid", 32'(digit_valid), 32'b0100);
        check("sb_final_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receiving end of the multiplexed seven-segment display interface.
- Samples the segment bus and the per-digit enable lines, and waits for each pattern to be stable.
- Converts each stable pattern back to its 4-bit hex value and keeps one register per digit.
- Used as a display monitor/loopback checker beside the segment encoder and scan logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYC, 4, consecutive identical samples required before capture (>=2, <=255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g}, bit6=a, active-high.
- an  input  NUM_DIGITS  digit enables, active-high, one-hot when driving.
- digits  output  4*NUM_DIGITS  recovered hex values; digit k at [4k+3:4k].
- digit_valid  output  NUM_DIGITS  digit k holds a valid capture.
- upd  output  1  one-cycle pulse on each successful capture.
- upd_idx  output  3  index of the digit captured with upd.
- pattern_err  output  1  one-cycle pulse: stable pattern not in the decode table.
- anode_err  output  1  one-cycle pulse: more than one bit of an set.

Behaviour:
- Reset, on the clk edge with rst=1: digits=0, digit_valid=0, upd=0, upd_idx=0, pattern_err=0, anode_err=0. Internal an_q=0, seg_q=0, cnt=0.
- rst has priority over every other event, including a capture on the same edge.
- Decode table (seg -> value):
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001
  - 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1110011, A:1110111, b:0011111
  - C:1001110, d:0111101, E:1001111, F:1000111
  - Any other pattern is invalid.
- Every edge: an_q<=an, seg_q<=seg. upd, pattern_err and anode_err default to 0.
- an all zero (idle): cnt<=0, no capture, no error.
- an multi-hot: cnt<=0, anode_err<=1, no capture.
- an one-hot, index k:
  - If an==an_q, seg==seg_q and cnt!=0: cnt<=min(cnt+1, STABLE_CYC).
  - Otherwise: cnt<=1.
- Capture happens on the edge where cnt goes from STABLE_CYC-1 to STABLE_CYC.
  - Outputs are visible after the STABLE_CYC-th consecutive identical sampled edge.
  - Exactly one capture per stable window. cnt saturates, so a held pattern never re-captures.
- Capture with a valid pattern: digits[k]<=value, digit_valid[k]<=1, upd<=1, upd_idx<=k.
- Capture with an invalid pattern: digits[k] unchanged, digit_valid[k]<=0, pattern_err<=1, upd=0.
- A seg or an change at any point before capture restarts the count at 1.
- Moving to a new digit index always restarts the count.
- Other digits' registers are never touched by a capture on digit k.

Optional Feature:
- Macro: SEVEN_SEGMENT_READER_BLANK_EN.
- Defined: a stable all-zero seg (blank digit) is legal on capture. digit_valid[k]<=0, digits[k]<=0, no pattern_err, no upd.
- Undefined: all-zero is an ordinary invalid pattern and raises pattern_err.

Decomposition:
- Shared package seven_segment_pkg:
  - 7-bit segment pattern typedef.
  - 16-entry pattern constant array, indexed by hex value.
  - BLANK pattern constant.
  - Shared with the encoder side.
- One combinational sub-module, seg_pattern_decode: input seg[6:0], outputs val[3:0] and hit.
- Stability counter, capture logic and digit registers stay in the top module.

Test Plan (NUM_DIGITS=4, STABLE_CYC=4):
- seg=1101101, an=0010 held 4 edges -> after 4th edge digits[7:4]=2, digit_valid=0010; upd high 1 cycle, upd_idx=1; held 6 more edges -> no further upd.
- Same stimulus held only 3 edges, then an=0000 -> no upd, digit_valid remains 0000.
- Scan digits 0..3 with 0110000, 1111001, 1000111, 1110111, 5 edges each -> digits=16'hA_F_3_1, digit_valid=1111, four upd pulses with upd_idx 0,1,2,3.
- seg=1010101, an=0001 held 4 edges after digit 0 was valid -> pattern_err pulse, digit_valid[0]=0, digits[3:0] unchanged.
- Boundary events, both giving no capture:
  - an=0011 -> anode_err pulse every edge while held.
  - rst asserted on the capture edge -> all outputs 0.
- seg=0000000, an=1000 held 4 edges -> with BLANK_EN: digit_valid[3]=0, no error. Without BLANK_EN: pattern_err pulse.
